// File: rtl/target_generator.sv
// Food target placement for the snake game: LFSR-driven draws on the 160x120 grid, one-cycle catch pulse.
// Optional TARGET_TIMEOUT_EN relocates an uncaught target after TIMEOUT_TICKS move ticks.
module target_generator #(
    parameter int         X_MAX         = 160,
    parameter int         Y_MAX         = 120,
    parameter logic [7:0] X_SEED        = 8'hB5,
    parameter logic [6:0] Y_SEED        = 7'h2A,
    parameter int         TIMEOUT_TICKS = 200
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] MSM_STATE,
    input  logic [7:0] HEAD_X,
    input  logic [6:0] HEAD_Y,
    input  logic       MOVE_TICK,
    output logic [7:0] TARGET_X,
    output logic [6:0] TARGET_Y,
    output logic       TARGET_VALID,
    output logic       TARGET_REACHED
);

    typedef enum logic [1:0] {IDLE, DRAW, ARMED} stateT;

    localparam logic [7:0] X_LIM = 8'(X_MAX);
    localparam logic [6:0] Y_LIM = 7'(Y_MAX);

    stateT      stateReg, stateNext;
    logic [7:0] lfsrXReg, lfsrXNext;
    logic [6:0] lfsrYReg, lfsrYNext;
    logic [7:0] targetXReg, targetXNext;
    logic [6:0] targetYReg, targetYNext;
    logic       validReg, validNext;
    logic       reachedReg, reachedNext;

    logic playing;
    logic sampleOk;
    logic headHit;
    logic timeoutHit;

`ifdef TARGET_TIMEOUT_EN
    localparam logic [7:0] TICK_LIM = 8'(TIMEOUT_TICKS);
    logic [7:0] tickCountReg, tickCountNext;
`else
    logic unusedTick;
    assign unusedTick = MOVE_TICK ^ (TIMEOUT_TICKS == 0);
`endif

    assign playing  = (MSM_STATE == 2'd1);
    // A draw is rejected off-grid and on the head cell, so a parked head never re-triggers.
    assign sampleOk = (lfsrXReg < X_LIM) && (lfsrYReg < Y_LIM) &&
                      !((lfsrXReg == HEAD_X) && (lfsrYReg == HEAD_Y));
    assign headHit  = (HEAD_X == targetXReg) && (HEAD_Y == targetYReg);

`ifdef TARGET_TIMEOUT_EN
    assign timeoutHit = (tickCountReg == TICK_LIM);
`else
    assign timeoutHit = 1'b0;
`endif

    always_comb begin
        lfsrXNext   = {lfsrXReg[6:0], lfsrXReg[7] ^ lfsrXReg[5] ^ lfsrXReg[4] ^ lfsrXReg[3]};
        lfsrYNext   = {lfsrYReg[5:0], lfsrYReg[6] ^ lfsrYReg[5]};
        stateNext   = stateReg;
        targetXNext = targetXReg;
        targetYNext = targetYReg;
        validNext   = validReg;
        reachedNext = 1'b0;
`ifdef TARGET_TIMEOUT_EN
        tickCountNext = tickCountReg;
`endif
        if (!playing) begin
            // Leaving play beats a same-cycle match and abandons any draw.
            stateNext = IDLE;
            validNext = 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    stateNext = DRAW;
                    validNext = 1'b0;
                end
                DRAW: begin
                    if (sampleOk) begin
                        targetXNext = lfsrXReg;
                        targetYNext = lfsrYReg;
                        validNext   = 1'b1;
                        stateNext   = ARMED;
`ifdef TARGET_TIMEOUT_EN
                        tickCountNext = 8'd0;
`endif
                    end
                end
                ARMED: begin
                    if (headHit) begin
                        reachedNext = 1'b1;
                        validNext   = 1'b0;
                        stateNext   = DRAW;
                    end else if (timeoutHit) begin
                        validNext = 1'b0;
                        stateNext = DRAW;
                    end
`ifdef TARGET_TIMEOUT_EN
                    else if (MOVE_TICK) begin
                        tickCountNext = tickCountReg + 8'd1;
                    end
`endif
                end
                default: begin
                    stateNext = IDLE;
                    validNext = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stateReg   <= IDLE;
            lfsrXReg   <= X_SEED;
            lfsrYReg   <= Y_SEED;
            targetXReg <= 8'd80;
            targetYReg <= 7'd60;
            validReg   <= 1'b0;
            reachedReg <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            lfsrXReg   <= lfsrXNext;
            lfsrYReg   <= lfsrYNext;
            targetXReg <= targetXNext;
            targetYReg <= targetYNext;
            validReg   <= validNext;
            reachedReg <= reachedNext;
        end
    end

`ifdef TARGET_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tickCountReg <= 8'd0;
        end else begin
            tickCountReg <= tickCountNext;
        end
    end
`endif

    assign TARGET_X       = targetXReg;
    assign TARGET_Y       = targetYReg;
    assign TARGET_VALID   = validReg;
    assign TARGET_REACHED = reachedReg;

endmodule

// File: tb/tb_target_generator.sv
// Scoreboard bench for target_generator: stimulus queues expected pulse cycles, a negedge monitor checks them.
module tb_target_generator;

`ifdef TARGET_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 200;
`endif

    logic       CLK = 1'b0;
    logic       RESET;
    logic [1:0] MSM_STATE;
    logic [7:0] HEAD_X;
    logic [6:0] HEAD_Y;
    logic       MOVE_TICK;
    logic [7:0] TARGET_X;
    logic [6:0] TARGET_Y;
    logic       TARGET_VALID;
    logic       TARGET_REACHED;

    target_generator #(.TIMEOUT_TICKS(TB_TIMEOUT)) dut (
        .CLK(CLK), .RESET(RESET), .MSM_STATE(MSM_STATE),
        .HEAD_X(HEAD_X), .HEAD_Y(HEAD_Y), .MOVE_TICK(MOVE_TICK),
        .TARGET_X(TARGET_X), .TARGET_Y(TARGET_Y),
        .TARGET_VALID(TARGET_VALID), .TARGET_REACHED(TARGET_REACHED)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int expPulse[$];
    int pulseCount = 0;
    int lastPulseCyc = -1;
    logic prevValid = 1'b0;
    logic prevReached = 1'b0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: pops one expected pulse per observed TARGET_REACHED and vets every fresh target.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (TARGET_REACHED) begin
                pulseCount++;
                check(!prevReached, "pulse_single_cycle", int'(prevReached), 0);
                check(!TARGET_VALID, "valid_low_on_pulse", int'(TARGET_VALID), 0);
                if (expPulse.size() == 0) begin
                    check(1'b0, "unexpected_pulse", cyc, -1);
                end else begin
                    int e;
                    e = expPulse.pop_front();
                    check(cyc == e, "pulse_cycle", cyc, e);
                end
                lastPulseCyc = cyc;
            end
            if (TARGET_VALID && !prevValid) begin
                check(TARGET_X < 8'd160, "target_x_range", int'(TARGET_X), 159);
                check(TARGET_Y < 7'd120, "target_y_range", int'(TARGET_Y), 119);
                check(!(TARGET_X == HEAD_X && TARGET_Y == HEAD_Y), "target_not_head",
                      {TARGET_X, 1'b0, TARGET_Y}, {HEAD_X, 1'b0, HEAD_Y});
                if (lastPulseCyc >= 0)
                    check(cyc > lastPulseCyc, "relatch_after_pulse", cyc, lastPulseCyc + 1);
            end
        end
        prevValid   = TARGET_VALID;
        prevReached = TARGET_REACHED;
    end

    // Inputs change 1 ns after the negedge so the monitor always sees the previous values.
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic waitValid(input int bound, input string name);
        int n;
        n = 0;
        while (!TARGET_VALID && n < bound) begin
            step();
            n++;
        end
        check(TARGET_VALID, name, n, bound);
    endtask

    task automatic catchTarget();
        HEAD_X = TARGET_X;
        HEAD_Y = TARGET_Y;
        expPulse.push_back(cyc + 1);
    endtask

    logic [7:0] savedX;
    logic [6:0] savedY;
    bit sawDrop;

    initial begin
        RESET = 1'b1; MSM_STATE = 2'd0; HEAD_X = 8'd0; HEAD_Y = 7'd0; MOVE_TICK = 1'b0;

        // 1: reset and idle
        repeat (5) step();
        check(TARGET_X == 8'd80 && TARGET_Y == 7'd60 && !TARGET_VALID && !TARGET_REACHED,
              "reset_state", {TARGET_X, TARGET_Y, TARGET_VALID, TARGET_REACHED}, {8'd80, 7'd60, 2'b00});
        RESET = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            check(TARGET_X == 8'd80 && TARGET_Y == 7'd60 && !TARGET_VALID && !TARGET_REACHED,
                  "idle_hold", {TARGET_X, TARGET_Y, TARGET_VALID, TARGET_REACHED}, {8'd80, 7'd60, 2'b00});
        end

        // 2: first draw
        MSM_STATE = 2'd1;
        waitValid(257, "first_draw_valid");

        // 3: single catch, head parked on the old target
        catchTarget();
        savedX = HEAD_X; savedY = HEAD_Y;
        repeat (30) step();
        check(pulseCount == 1, "parked_pulse_count", pulseCount, 1);
        check(TARGET_VALID, "redraw_valid", int'(TARGET_VALID), 1);
        check(!(TARGET_X == savedX && TARGET_Y == savedY), "redraw_not_head",
              {TARGET_X, TARGET_Y}, {savedX, savedY});

        // 4: ten catches
        for (int k = 0; k < 10; k++) begin
            waitValid(257, "catch_loop_valid");
            catchTarget();
            repeat (3) step();
        end
        check(pulseCount == 11, "ten_catch_count", pulseCount, 11);

        // 5a: leave play in the first draw cycle
        waitValid(257, "pre_abort_valid");
        savedX = TARGET_X; savedY = TARGET_Y;
        catchTarget();
        step();
        MSM_STATE = 2'd3;
        repeat (4) step();
        check(!TARGET_VALID && TARGET_X == savedX && TARGET_Y == savedY, "draw_abort_hold",
              {TARGET_VALID, TARGET_X, TARGET_Y}, {1'b0, savedX, savedY});
        MSM_STATE = 2'd1;
        waitValid(257, "draw_abort_redraw");

        // 5b: leave play in the match cycle, no pulse expected
        savedX = TARGET_X; savedY = TARGET_Y;
        HEAD_X = TARGET_X; HEAD_Y = TARGET_Y;
        MSM_STATE = 2'd3;
        repeat (5) step();
        check(pulseCount == 12, "match_abort_no_pulse", pulseCount, 12);
        check(!TARGET_VALID && TARGET_X == savedX && TARGET_Y == savedY, "match_abort_hold",
              {TARGET_VALID, TARGET_X, TARGET_Y}, {1'b0, savedX, savedY});
        MSM_STATE = 2'd1;
        waitValid(257, "match_abort_redraw");

        // 6: move ticks with the head off-grid
        HEAD_X = 8'd200; HEAD_Y = 7'd125;
        savedX = TARGET_X; savedY = TARGET_Y;
`ifdef TARGET_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            MOVE_TICK = 1'b1; step();
            MOVE_TICK = 1'b0; step();
        end
        sawDrop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!TARGET_VALID) sawDrop = 1'b1;
            step();
        end
        check(sawDrop, "timeout_relocate", int'(sawDrop), 1);
        check(pulseCount == 12, "timeout_no_pulse", pulseCount, 12);
`else
        for (int i = 0; i < 1000; i++) begin
            MOVE_TICK = 1'b1; step();
            MOVE_TICK = 1'b0; step();
        end
        sawDrop = !TARGET_VALID;
        check(!sawDrop && TARGET_X == savedX && TARGET_Y == savedY, "no_timeout_hold",
              {TARGET_VALID, TARGET_X, TARGET_Y}, {1'b1, savedX, savedY});
        check(pulseCount == 12, "no_timeout_no_pulse", pulseCount, 12);
`endif

        step();
        check(expPulse.size() == 0, "scoreboard_drained", expPulse.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
